// File: rtl/dp_ram_arb.sv
// dp_ram_arb: two-writer/two-reader round-robin front end for one dp_ram.
// Defining DP_RAM_ARB_BYPASS_EN forwards same-cycle write data to a colliding read.
module dp_ram_arb #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wreq0_valid,
    output logic                  wreq0_ready,
    input  logic [ADDR_WIDTH-1:0] wreq0_addr,
    input  logic [DATA_WIDTH-1:0] wreq0_data,
    input  logic                  wreq1_valid,
    output logic                  wreq1_ready,
    input  logic [ADDR_WIDTH-1:0] wreq1_addr,
    input  logic [DATA_WIDTH-1:0] wreq1_data,
    input  logic                  rreq0_valid,
    output logic                  rreq0_ready,
    input  logic [ADDR_WIDTH-1:0] rreq0_addr,
    input  logic                  rreq1_valid,
    output logic                  rreq1_ready,
    input  logic [ADDR_WIDTH-1:0] rreq1_addr,
    output logic                  rresp_valid,
    output logic                  rresp_id,
    output logic [DATA_WIDTH-1:0] rresp_data,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);
    logic wr_pri, rd_pri, resp_q;

    always_comb begin
        wreq0_ready = !rst && wreq0_valid && (!wreq1_valid || !wr_pri);
        wreq1_ready = !rst && wreq1_valid && (!wreq0_valid || wr_pri);
        rreq0_ready = !rst && rreq0_valid && (!rreq1_valid || !rd_pri);
        rreq1_ready = !rst && rreq1_valid && (!rreq0_valid || rd_pri);
        ram_wr_en   = wreq0_ready || wreq1_ready;
        ram_wr_addr = wreq1_ready ? wreq1_addr : wreq0_addr;
        ram_wr_data = wreq1_ready ? wreq1_data : wreq0_data;
        ram_rd_en   = rreq0_ready || rreq1_ready;
        ram_rd_addr = rreq1_ready ? rreq1_addr : rreq0_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_pri   <= 1'b0;
            rd_pri   <= 1'b0;
            resp_q   <= 1'b0;
            rresp_id <= 1'b0;
        end else begin
            if (ram_wr_en) wr_pri <= wreq0_ready;
            if (ram_rd_en) rd_pri <= rreq0_ready;
            resp_q   <= ram_rd_en;
            rresp_id <= rreq1_ready;
        end
    end

    assign rresp_valid = resp_q && !rst;

`ifdef DP_RAM_ARB_BYPASS_EN
    logic                  hit;
    logic [DATA_WIDTH-1:0] byp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit      <= 1'b0;
            byp_data <= '0;
        end else begin
            hit      <= ram_wr_en && ram_rd_en && (ram_wr_addr == ram_rd_addr);
            byp_data <= ram_wr_data;
        end
    end

    assign rresp_data = hit ? byp_data : ram_rd_data;
`else
    assign rresp_data = ram_rd_data;
`endif
endmodule

// File: tb/tb_dp_ram_arb.sv
// tb_dp_ram_arb: directed checks of dp_ram_arb against a behavioural dp_ram.
module tb_dp_ram_arb;
    localparam int AW = 10;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          wreq0_valid, wreq0_ready, wreq1_valid, wreq1_ready;
    logic [AW-1:0] wreq0_addr, wreq1_addr;
    logic [DW-1:0] wreq0_data, wreq1_data;
    logic          rreq0_valid, rreq0_ready, rreq1_valid, rreq1_ready;
    logic [AW-1:0] rreq0_addr, rreq1_addr;
    logic          rresp_valid, rresp_id;
    logic [DW-1:0] rresp_data;
    logic          ram_wr_en, ram_rd_en;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_wr_data, ram_rd_data;
    logic [DW-1:0] mem [2**AW];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    dp_ram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .wreq0_valid(wreq0_valid), .wreq0_ready(wreq0_ready), .wreq0_addr(wreq0_addr), .wreq0_data(wreq0_data),
        .wreq1_valid(wreq1_valid), .wreq1_ready(wreq1_ready), .wreq1_addr(wreq1_addr), .wreq1_data(wreq1_data),
        .rreq0_valid(rreq0_valid), .rreq0_ready(rreq0_ready), .rreq0_addr(rreq0_addr),
        .rreq1_valid(rreq1_valid), .rreq1_ready(rreq1_ready), .rreq1_addr(rreq1_addr),
        .rresp_valid(rresp_valid), .rresp_id(rresp_id), .rresp_data(rresp_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wreq0_valid = 0; wreq1_valid = 0; rreq0_valid = 0; rreq1_valid = 0;
    endtask

    task automatic do_reset;
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        wreq0_addr = 0; wreq1_addr = 0; wreq0_data = 0; wreq1_data = 0;
        rreq0_addr = 0; rreq1_addr = 0;
        do_reset();
        chk("reset_rresp_valid", rresp_valid, 0);
        chk("reset_rresp_id", rresp_id, 0);

        // 1: write then read back through requester 1
        wreq0_valid = 1; wreq0_addr = 5; wreq0_data = 'hA5;
        #1;
        chk("t1_wready0", wreq0_ready, 1);
        chk("t1_wr_en", ram_wr_en, 1);
        chk("t1_wr_addr", ram_wr_addr, 5);
        chk("t1_wr_data", ram_wr_data, 'hA5);
        tick();
        wreq0_valid = 0; rreq1_valid = 1; rreq1_addr = 5;
        #1;
        chk("t1_rready1", rreq1_ready, 1);
        chk("t1_rd_en", ram_rd_en, 1);
        chk("t1_rd_addr", ram_rd_addr, 5);
        tick();
        rreq1_valid = 0;
        chk("t1_resp_valid", rresp_valid, 1);
        chk("t1_resp_id", rresp_id, 1);
        chk("t1_resp_data", rresp_data, 'hA5);
        tick();
        chk("t1_resp_gone", rresp_valid, 0);

        // 2: write round robin from reset
        do_reset();
        wreq0_valid = 1; wreq1_valid = 1;
        wreq0_addr = 1; wreq0_data = 'h1; wreq1_addr = 2; wreq1_data = 'h2;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_rr_w0", wreq0_ready, (k % 2) == 0);
            chk("t2_rr_w1", wreq1_ready, (k % 2) == 1);
            chk("t2_rr_addr", ram_wr_addr, (k % 2) ? 2 : 1);
            tick();
        end
        wreq1_valid = 0;
        #1;
        chk("t2_solo_w0", wreq0_ready, 1);
        tick();
        wreq1_valid = 1;
        #1;
        chk("t2_after_w0", wreq0_ready, 0);
        chk("t2_after_w1", wreq1_ready, 1);
        chk("t2_after_data", ram_wr_data, 'h2);
        tick();
        idle();

        // 3: preload 0..3, then stream reads from both requesters
        for (int a = 0; a < 4; a++) begin
            wreq0_valid = 1; wreq0_addr = AW'(a); wreq0_data = DW'(32'h100 + a);
            tick();
        end
        idle();
        begin
            int i0, i1, a;
            i0 = 0; i1 = 0;
            for (int k = 0; k < 8; k++) begin
                rreq0_valid = i0 < 4; rreq0_addr = AW'(i0);
                rreq1_valid = i1 < 4; rreq1_addr = AW'(i1);
                #1;
                chk("t3_r0", rreq0_ready, (k % 2) == 0);
                chk("t3_r1", rreq1_ready, (k % 2) == 1);
                a = (k % 2) ? i1 : i0;
                chk("t3_rd_addr", ram_rd_addr, AW'(a));
                if (k % 2) i1++; else i0++;
                tick();
                chk("t3_resp_valid", rresp_valid, 1);
                chk("t3_resp_id", rresp_id, (k % 2) == 1);
                chk("t3_resp_data", rresp_data, DW'(32'h100 + a));
            end
        end
        idle();
        tick();
        chk("t3_resp_end", rresp_valid, 0);

        // 4: same-address write and read in one cycle
        wreq0_valid = 1; wreq0_addr = 7; wreq0_data = 'h11;
        tick();
        wreq0_data = 'h22; rreq0_valid = 1; rreq0_addr = 7;
        #1;
        chk("t4_wready", wreq0_ready, 1);
        chk("t4_rready", rreq0_ready, 1);
        tick();
        idle();
`ifdef DP_RAM_ARB_BYPASS_EN
        chk("t4_collide_data", rresp_data, 'h22);
`else
        chk("t4_collide_data", rresp_data, 'h11);
`endif
        rreq0_valid = 1;
        tick();
        rreq0_valid = 0;
        chk("t4_reread", rresp_data, 'h22);

        // 5: reset right after a read grant; both pointers now 1
        rreq0_valid = 1; rreq0_addr = 3;
        #1;
        chk("t5_grant", rreq0_ready, 1);
        tick();
        rst = 1;
        wreq0_valid = 1; wreq1_valid = 1; rreq0_valid = 1; rreq1_valid = 1;
        wreq0_addr = 10; wreq1_addr = 11; rreq0_addr = 0; rreq1_addr = 1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t5_rst_resp", rresp_valid, 0);
            chk("t5_rst_grants", {wreq0_ready, wreq1_ready, rreq0_ready, rreq1_ready}, 0);
            chk("t5_rst_en", {ram_wr_en, ram_rd_en}, 0);
            tick();
        end
        rst = 0;
        #1;
        chk("t5_wptr0", {wreq0_ready, wreq1_ready}, 2'b10);
        chk("t5_rptr0", {rreq0_ready, rreq1_ready}, 2'b10);
        chk("t5_post_resp", rresp_valid, 0);
        tick();
        idle();
        chk("t5_resp", rresp_valid, 1);

        // 6: ten idle cycles, pointers (both 1) must hold
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t6_en", {ram_wr_en, ram_rd_en, rresp_valid}, 0);
            chk("t6_mux_wr", ram_wr_addr, 10);
            chk("t6_mux_rd", ram_rd_addr, 0);
        end
        wreq0_valid = 1; wreq1_valid = 1; rreq0_valid = 1; rreq1_valid = 1;
        #1;
        chk("t6_wptr_held", {wreq0_ready, wreq1_ready}, 2'b01);
        chk("t6_rptr_held", {rreq0_ready, rreq1_ready}, 2'b01);
        tick();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
